mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through and performs single-beat LW/SW
// handshakes with data memory. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int REG_LENGTH     = 32,
  parameter int REG_ADDR_LEN   = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_LENGTH-1:0]   regcData_i,
  input  logic [REG_ADDR_LEN-1:0] regcAddr_i,
  input  logic                    regcWr_i,
  input  logic [1:0]              memOp_i,
  input  logic [REG_LENGTH-1:0]   memWData_i,
  input  logic [REG_LENGTH-1:0]   memRData,
  input  logic                    memAck,
  output logic                    memReq,
  output logic                    memWe,
  output logic [REG_LENGTH-1:0]   memAddr,
  output logic [REG_LENGTH-1:0]   memWData,
  output logic [REG_LENGTH-1:0]   regcData,
  output logic [REG_ADDR_LEN-1:0] regcAddr,
  output logic                    regcWr,
  output logic                    stall,
  output logic                    memErr
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    start_s;
  logic                    done_s;
  logic                    mem_req_r;
  logic                    mem_we_r;
  logic [REG_LENGTH-1:0]   mem_addr_r;
  logic [REG_LENGTH-1:0]   mem_wdata_r;
  logic [REG_LENGTH-1:0]   regc_data_r;
  logic [REG_ADDR_LEN-1:0] regc_addr_r;
  logic                    regc_wr_r;
  logic [REG_ADDR_LEN-1:0] pend_addr_r;
  logic                    pend_wr_r;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_r;
  logic             abort_s;
  logic             mem_err_r;
`endif

  // Next-state decode; a same-edge ack always wins over the timeout abort
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    done_s      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    abort_s     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if ((memOp_i == 2'b01) || (memOp_i == 2'b10)) begin
          start_s     = 1'b1;
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (memAck) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
`endif
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request, captured access and writeback registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      regc_data_r <= '0;
      regc_addr_r <= '0;
      regc_wr_r   <= 1'b0;
      pend_addr_r <= '0;
      pend_wr_r   <= 1'b0;
    end else begin
      mem_req_r <= (state_nxt_s == ACCESS);
      if (start_s) begin
        mem_addr_r  <= {regcData_i[REG_LENGTH-1:2], 2'b00};
        mem_we_r    <= (memOp_i == 2'b10);
        mem_wdata_r <= memWData_i;
        pend_addr_r <= regcAddr_i;
        pend_wr_r   <= regcWr_i;
        regc_wr_r   <= 1'b0;
      end else if (state_r == IDLE) begin
        regc_data_r <= regcData_i;
        regc_addr_r <= regcAddr_i;
        regc_wr_r   <= regcWr_i;
      end else if (done_s && !mem_we_r) begin
        regc_data_r <= memRData;
        regc_addr_r <= pend_addr_r;
        regc_wr_r   <= pend_wr_r;
      end else begin
        // stores, aborts and waiting cycles never write back
        regc_wr_r   <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Counts ACCESS cycles without ack; error flag pulses for one cycle on abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r  <= '0;
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= abort_s;
      if (start_s) begin
        to_cnt_r <= '0;
      end else if ((state_r == ACCESS) && !memAck) begin
        to_cnt_r <= to_cnt_r + CNT_W'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  assign memErr = mem_err_r;
`else
  assign memErr = 1'b0;
`endif

  assign stall    = (state_r == ACCESS);
  assign memReq   = mem_req_r;
  assign memWe    = mem_we_r;
  assign memAddr  = mem_addr_r;
  assign memWData = mem_wdata_r;
  assign regcData = regc_data_r;
  assign regcAddr = regc_addr_r;
  assign regcWr   = regc_wr_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic against a
// transaction-level reference model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] regc_data_i = '0;
  logic [4:0]  regc_addr_i = '0;
  logic        regc_wr_i = 1'b0;
  logic [1:0]  mem_op_i = 2'b00;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, regc_wr, stall, mem_err;
  logic [31:0] mem_addr, mem_wdata, regc_data;
  logic [4:0]  regc_addr;

  int checks = 0;
  int failures = 0;

  // reference model: one outstanding transaction
  bit          m_busy;
  bit          m_is_sw;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_pend_addr;
  bit          m_pend_wr;
  int          m_wait;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  bit          e_wr, e_err;

  mem_stage #(.REG_LENGTH(32), .REG_ADDR_LEN(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .regcData_i(regc_data_i), .regcAddr_i(regc_addr_i), .regcWr_i(regc_wr_i),
    .memOp_i(mem_op_i), .memWData_i(mem_wdata_i),
    .memRData(mem_rdata), .memAck(mem_ack),
    .memReq(mem_req), .memWe(mem_we), .memAddr(mem_addr), .memWData(mem_wdata),
    .regcData(regc_data), .regcAddr(regc_addr), .regcWr(regc_wr),
    .stall(stall), .memErr(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_sw = 0; m_addr = '0; m_wdata = '0;
    m_pend_addr = '0; m_pend_wr = 0; m_wait = 0;
    e_data = '0; e_addr = '0; e_wr = 0; e_err = 0;
  endtask

  task automatic model_edge();
    e_err = 0;
    if (!m_busy) begin
      if (mem_op_i == 2'd1 || mem_op_i == 2'd2) begin
        m_busy = 1; m_is_sw = (mem_op_i == 2'd2);
        m_addr = regc_data_i & 32'hFFFF_FFFC; m_wdata = mem_wdata_i;
        m_pend_addr = regc_addr_i; m_pend_wr = regc_wr_i;
        m_wait = 0; e_wr = 0;
      end else begin
        e_data = regc_data_i; e_addr = regc_addr_i; e_wr = regc_wr_i;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      if (m_is_sw) e_wr = 0;
      else begin e_data = mem_rdata; e_addr = m_pend_addr; e_wr = m_pend_wr; end
    end else begin
      m_wait++;
`ifdef MEM_TIMEOUT_EN
      if (m_wait == TO) begin m_busy = 0; e_wr = 0; e_err = 1; end
`endif
    end
  endtask

  task automatic compare();
    chk("memReq", 32'(mem_req), 32'(m_busy));
    chk("stall", 32'(stall), 32'(m_busy));
    chk("regcWr", 32'(regc_wr), 32'(e_wr));
    chk("regcData", regc_data, e_data);
    chk("regcAddr", 32'(regc_addr), 32'(e_addr));
    chk("memErr", 32'(mem_err), 32'(e_err));
    if (m_busy) begin
      chk("memAddr", mem_addr, m_addr);
      chk("memWe", 32'(mem_we), 32'(m_is_sw));
      chk("memWData", mem_wdata, m_wdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_ex(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                        input logic w, input logic [31:0] wd);
    mem_op_i = op; regc_data_i = d; regc_addr_i = a; regc_wr_i = w; mem_wdata_i = wd;
  endtask

  initial begin
    int stall_cnt;
    model_reset();
    #12;
    chk("rst_memReq", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_regcData", regc_data, 32'd0);
    chk("rst_memAddr", mem_addr, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    set_ex(2'b00, 32'h5, 5'd3, 1'b1, 32'h0);
    step();
    chk("alu_data", regc_data, 32'h5);
    chk("alu_addr", 32'(regc_addr), 32'd3);
    chk("alu_wr", 32'(regc_wr), 32'd1);
    chk("alu_stall", 32'(stall), 32'd0);

    // LW with three wait cycles
    set_ex(2'b01, 32'h103, 5'd7, 1'b1, 32'hAAAA_0000);
    mem_ack = 1'b0;
    step();
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_we", 32'(mem_we), 32'd0);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) stall_cnt++;
      set_ex(2'b10, $urandom, 5'($urandom), 1'b1, $urandom);
      mem_ack = (i == 3);
      mem_rdata = (i == 3) ? 32'hDEAD_BEEF : $urandom;
      step();
    end
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_data", regc_data, 32'hDEAD_BEEF);
    chk("lw_wr", 32'(regc_wr), 32'd1);
    chk("lw_raddr", 32'(regc_addr), 32'd7);

    // SW acked in first ACCESS cycle, then back-to-back LW
    set_ex(2'b10, 32'h20, 5'd9, 1'b1, 32'h1234_5678);
    mem_ack = 1'b0;
    step();
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    chk("sw_addr", mem_addr, 32'h20);
    mem_ack = 1'b1;
    step();
    chk("sw_stall_done", 32'(stall), 32'd0);
    chk("sw_wr", 32'(regc_wr), 32'd0);
    set_ex(2'b01, 32'h44, 5'd2, 1'b1, 32'h0);
    mem_ack = 1'b0;
    step();
    chk("b2b_stall", 32'(stall), 32'd1);
    chk("b2b_addr", mem_addr, 32'h44);

    // reset during second ACCESS cycle
    step();
    #2 rst = 1'b0;
    #1;
    chk("midrst_memReq", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    model_reset();
    compare();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_wr", 32'(regc_wr), 32'd0);
    set_ex(2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
    step();

`ifdef MEM_TIMEOUT_EN
    // timeout abort, then ack arriving on the last allowed cycle
    set_ex(2'b01, 32'h80, 5'd4, 1'b1, 32'h0);
    mem_ack = 1'b0;
    step();
    set_ex(2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
    for (int i = 0; i < TO; i++) step();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_wr", 32'(regc_wr), 32'd0);
    step();
    chk("to_err_pulse", 32'(mem_err), 32'd0);
    set_ex(2'b01, 32'h84, 5'd6, 1'b1, 32'h0);
    step();
    set_ex(2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
    for (int i = 0; i < TO; i++) begin
      mem_ack = (i == TO - 1);
      mem_rdata = 32'hCAFE_F00D;
      step();
    end
    chk("to_ack_err", 32'(mem_err), 32'd0);
    chk("to_ack_data", regc_data, 32'hCAFE_F00D);
    chk("to_ack_wr", 32'(regc_wr), 32'd1);
    mem_ack = 1'b0;
`endif

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      set_ex(2'($urandom_range(0, 3)), $urandom, 5'($urandom), 1'($urandom), $urandom);
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
